// File: rtl/mem_reader_pkg.sv
// Shared constants, FSM state type and bounds helper for the pixel-memory window reader.
package mem_reader_pkg;

    // Bytes returned by one parallel memory read
    localparam int unsigned WIN       = 50;
    // Memory address width
    localparam int unsigned ADDR_W    = 16;
    // Number of addressable memory bytes
    localparam int unsigned MEM_DEPTH = 2048;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        STREAM,
        FINISH
    } state_t;

    // True when the whole window starting at addr lies inside the memory.
    // Evaluated one bit wider than the address so a high base cannot wrap past zero.
    function automatic logic window_fits(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W:0] win_end;
        win_end = {1'b0, addr} + (ADDR_W+1)'(WIN - 1);
        return win_end <= (ADDR_W+1)'(MEM_DEPTH - 1);
    endfunction

endpackage

// File: rtl/win_shift_buf.sv
// WIN-byte parallel-load buffer that presents one byte at a time, lowest byte first.
module win_shift_buf
    import mem_reader_pkg::*;
#(
    parameter int unsigned BYTES = WIN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               advance,
    input  logic [BYTES*8-1:0] din,
    output logic [7:0]         data,
    output logic               last
);

    localparam int unsigned        IDX_W    = $clog2(BYTES);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(BYTES - 1);

    logic [BYTES*8-1:0] bytes_q;
    logic [IDX_W-1:0]   idx;

    // Shifting instead of index-muxing keeps the presented byte a direct flop output
    always_ff @(posedge clk) begin
        if (rst) begin
            bytes_q <= '0;
            idx     <= '0;
        end else if (load) begin
            bytes_q <= din;
            idx     <= '0;
        end else if (advance) begin
            bytes_q <= {8'h00, bytes_q[BYTES*8-1:8]};
            idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    assign data = bytes_q[7:0];
    assign last = (idx == LAST_IDX);

endmodule

// File: rtl/mem_window_reader.sv
// Fetches consecutive WIN-byte windows from the pixel memory and streams them byte-wise.
module mem_window_reader
    import mem_reader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [7:0]          num_windows,
    output logic                busy,
    output logic                done,
    output logic                addr_err,
    output logic                mem_en,
    output logic                mem_rw,
    output logic [ADDR_W-1:0]   mem_abus,
    input  logic [WIN*8-1:0]    mem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_data,
    output logic                out_last
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WIN);

    state_t              state;
    logic [ADDR_W-1:0]   cur_addr;
    logic [7:0]          remaining;
    logic                issued;
    logic [1:0]          fin_dly;
    logic                fire;
    logic                buf_load;
    logic                buf_adv;

    assign fire     = out_valid & out_ready;
    assign buf_load = (state == CAPTURE);
    assign buf_adv  = (state == STREAM) & fire;

    // The reader never writes the memory
    assign mem_rw = 1'b1;

    win_shift_buf #(
        .BYTES (WIN)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (buf_load),
        .advance (buf_adv),
        .din     (mem_rdata),
        .data    (out_data),
        .last    (out_last)
    );

    // Control FSM; every output is registered alongside the state change
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            issued    <= 1'b0;
            fin_dly   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr_err  <= 1'b0;
            mem_en    <= 1'b0;
            mem_abus  <= '0;
            out_valid <= 1'b0;
        end else begin
            done     <= 1'b0;
            addr_err <= 1'b0;
            mem_en   <= 1'b0;
            mem_abus <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr  <= base_addr;
                        remaining <= num_windows;
                        issued    <= 1'b0;
                        busy      <= 1'b1;
                        if (num_windows == 8'd0) begin
                            // Empty request: done lands where the first read would have finished
                            fin_dly <= 2'd2;
                            state   <= FINISH;
                        end else begin
                            fin_dly <= 2'd0;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // Two cycles: bounds check and drive the bus, then hold while memory answers
                    if (!issued) begin
                        if (window_fits(cur_addr)) begin
                            mem_en   <= 1'b1;
                            mem_abus <= cur_addr;
                            issued   <= 1'b1;
                        end else begin
                            done     <= 1'b1;
                            addr_err <= 1'b1;
                            state    <= FINISH;
                        end
                    end else begin
                        issued <= 1'b0;
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    out_valid <= 1'b1;
                    state     <= STREAM;
                end
                STREAM: begin
                    if (fire && out_last) begin
                        out_valid <= 1'b0;
                        if (remaining > 8'd1) begin
                            remaining <= remaining - 8'd1;
                            cur_addr  <= cur_addr + STEP;
                            state     <= ISSUE;
                        end else begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    if (fin_dly != 2'd0) begin
                        fin_dly <= fin_dly - 2'd1;
                        if (fin_dly == 2'd1) begin
                            done <= 1'b1;
                        end
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_window_reader.sv
// Self-checking bench for mem_window_reader: directed vector table, reset and
// start-while-busy sequences, and randomized runs against a window-level model.
module tb_mem_window_reader;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  base_addr;
    logic [7:0]   num_windows;
    logic         busy;
    logic         done;
    logic         addr_err;
    logic         mem_en;
    logic         mem_rw;
    logic [15:0]  mem_abus;
    logic [399:0] mem_rdata;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic         out_last;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:2047];

    // Run observations
    int         done_cnt, err_cnt, err_stray, busy_bad, idle_abus_bad, rw_bad, stall_bad, post_bad;
    int         done_cyc, first_valid_cyc, first_en_cyc;
    logic [7:0] got_bytes [$];
    bit         got_last  [$];
    int         got_abus  [$];
    // Model expectations
    logic [7:0] exp_bytes [$];
    int         exp_abus  [$];
    int         exp_err;

    typedef struct {
        int base;
        int nw;
        int mode;       // 0: ready always 1, 1: ready toggles 1/0, 2: random
        int poke;       // cycle to pulse start while busy, -1 for none
        int exp_reads;
        int exp_err;
        int exp_done;   // done cycle after the start edge, -1 when not checked
    } vec_t;

    vec_t tv [10];

    mem_window_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .num_windows (num_windows),
        .busy        (busy),
        .done        (done),
        .addr_err    (addr_err),
        .mem_en      (mem_en),
        .mem_rw      (mem_rw),
        .mem_abus    (mem_abus),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [399:0] junk();
        logic [399:0] r;
        for (int i = 0; i < 50; i++) r[8*i +: 8] = 8'($urandom);
        return r;
    endfunction

    function automatic logic [399:0] window_of(input logic [15:0] a);
        logic [399:0] r;
        for (int i = 0; i < 50; i++) begin
            int idx;
            idx = int'(a) + i;
            r[8*i +: 8] = (idx < 2048) ? mem[idx] : 8'($urandom);
        end
        return r;
    endfunction

    // Synchronous memory: answers the clock edge that sees mem_en, garbage otherwise
    always @(posedge clk) begin
        mem_rdata <= mem_en ? window_of(mem_abus) : junk();
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    // Window-level reference: walk windows, stop at the first one that leaves memory
    task automatic model(input int base, input int nw);
        int addr;
        exp_bytes.delete();
        exp_abus.delete();
        exp_err = 0;
        addr = base;
        for (int w = 0; w < nw; w++) begin
            if (addr + 49 > 2047) begin
                exp_err = 1;
                break;
            end
            exp_abus.push_back(addr);
            for (int j = 0; j < 50; j++) exp_bytes.push_back(mem[addr + j]);
            addr = (addr + 50) % 65536;
        end
    endtask

    task automatic run_req(input int base, input int nw, input int mode, input int poke, input string tag);
        int limit, nbad, first, k, exp_done;
        bit prev_v, prev_r, prev_l;
        logic [7:0] prev_d;
        done_cnt = 0; err_cnt = 0; err_stray = 0; busy_bad = 0; idle_abus_bad = 0;
        rw_bad = 0; stall_bad = 0; post_bad = 0;
        done_cyc = -1; first_valid_cyc = -1; first_en_cyc = -1;
        got_bytes.delete(); got_last.delete(); got_abus.delete();
        prev_v = 0; prev_r = 0; prev_l = 0; prev_d = 8'h00;
        model(base, nw);

        @(negedge clk);
        base_addr   = 16'(base);
        num_windows = 8'(nw);
        out_ready   = 1'b0;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        limit = 300 * nw + 60;
        for (int c = 0; c < limit; c++) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (c == poke && done_cyc < 0) begin
                start       = 1'b1;
                base_addr   = 16'd1000;
                num_windows = 8'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (mem_rw !== 1'b1) rw_bad++;
            if (mem_en) begin
                got_abus.push_back(int'(mem_abus));
                if (first_en_cyc < 0) first_en_cyc = c;
            end else if (mem_abus !== 16'd0) begin
                idle_abus_bad++;
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = c;
            if (prev_v && !prev_r)
                if (!out_valid || out_data !== prev_d || out_last !== prev_l) stall_bad++;
            if (out_valid && out_ready) begin
                got_bytes.push_back(out_data);
                got_last.push_back(out_last);
            end
            if (addr_err && !done) err_stray++;
            if (addr_err) err_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc < 0 || c <= done_cyc) begin
                if (busy !== 1'b1) busy_bad++;
            end else begin
                if (busy !== 1'b0) busy_bad++;
                if (out_valid || mem_en) post_bad++;
            end
            prev_v = out_valid; prev_r = out_ready; prev_d = out_data; prev_l = out_last;
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
            @(posedge clk);
            #1;
        end
        start = 1'b0;

        check({tag, " done pulses"}, done_cnt, 1);
        check({tag, " addr_err pulses"}, err_cnt, exp_err);
        check({tag, " addr_err without done"}, err_stray, 0);
        check({tag, " read count"}, got_abus.size(), exp_abus.size());
        nbad = 0; first = -1;
        for (int i = 0; i < got_abus.size() && i < exp_abus.size(); i++)
            if (got_abus[i] != exp_abus[i]) begin nbad++; if (first < 0) first = i; end
        check($sformatf("%s read addresses (first bad %0d)", tag, first), nbad, 0);
        check({tag, " byte count"}, got_bytes.size(), exp_bytes.size());
        nbad = 0; first = -1;
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
            if (got_bytes[i] !== exp_bytes[i]) begin nbad++; if (first < 0) first = i; end
        check($sformatf("%s byte values (first bad %0d)", tag, first), nbad, 0);
        nbad = 0; first = -1;
        for (int i = 0; i < got_last.size(); i++)
            if (got_last[i] != (i % 50 == 49)) begin nbad++; if (first < 0) first = i; end
        check($sformatf("%s out_last placement (first bad %0d)", tag, first), nbad, 0);
        check({tag, " busy window violations"}, busy_bad, 0);
        check({tag, " abus nonzero while disabled"}, idle_abus_bad, 0);
        check({tag, " mem_rw not read"}, rw_bad, 0);
        check({tag, " data unstable during stall"}, stall_bad, 0);
        check({tag, " activity after done"}, post_bad, 0);
        if (mode == 0) begin
            k = exp_abus.size();
            exp_done = (nw == 0) ? 2 : (exp_err != 0 ? 53 * k + 1 : 53 * k);
            check({tag, " done cycle"}, done_cyc, exp_done);
            if (k > 0) begin
                check({tag, " first mem_en cycle"}, first_en_cyc, 1);
                check({tag, " first out_valid cycle"}, first_valid_cyc, 3);
            end
        end
    endtask

    initial begin
        int nbytes, base, nw, mode, poke;
        bit saw_done;

        rst = 1'b1; start = 1'b0; base_addr = '0; num_windows = '0; out_ready = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i);

        repeat (3) @(posedge clk);
        #1;
        check("reset outputs",
              int'({busy, done, addr_err, mem_en, mem_rw, mem_abus, out_valid, out_last, out_data}),
              int'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00}));
        rst = 1'b0;

        tv[0] = '{100,   1, 0, -1, 1, 0,  53};
        tv[1] = '{0,     3, 1, -1, 3, 0,  -1};
        tv[2] = '{0,     0, 0, -1, 0, 0,   2};
        tv[3] = '{1990,  2, 0, -1, 1, 1,  54};
        tv[4] = '{1998,  1, 0, -1, 1, 0,  53};
        tv[5] = '{1999,  1, 0, -1, 0, 1,   1};
        tv[6] = '{65530, 1, 0, -1, 0, 1,   1};
        tv[7] = '{1900,  5, 0, -1, 2, 1, 107};
        tv[8] = '{200,   2, 0, 30, 2, 0, 106};
        tv[9] = '{0,     3, 0, -1, 3, 0, 159};

        for (int i = 0; i < 10; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_req(tv[i].base, tv[i].nw, tv[i].mode, tv[i].poke, tag);
            check({tag, " table read count"}, got_abus.size(), tv[i].exp_reads);
            check({tag, " table addr_err"}, err_cnt, tv[i].exp_err);
            if (tv[i].exp_done >= 0) check({tag, " table done cycle"}, done_cyc, tv[i].exp_done);
        end

        // Reset in the middle of a window, then a clean run
        @(negedge clk);
        base_addr = 16'd500; num_windows = 8'd2; out_ready = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nbytes = 0; saw_done = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done) saw_done = 1;
            if (out_valid && out_ready) begin
                if (nbytes == 20) break;
                nbytes++;
            end
            @(posedge clk);
            #1;
        end
        check("rst: reached byte 20", nbytes, 20);
        check("rst: byte 20 value", int'(out_data), 520 % 256);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst: outputs after mid-run reset",
              int'({busy, done, addr_err, mem_en, mem_rw, mem_abus, out_valid, out_last, out_data}),
              int'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00}));
        saw_done = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done || busy || out_valid || mem_en) saw_done = 1;
        end
        check("rst: quiet after reset", int'(saw_done), 0);
        run_req(700, 1, 0, -1, "post-rst");

        // Randomized runs on random memory contents
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        for (int r = 0; r < 20; r++) begin
            base = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1850, 2047)) : int'($urandom_range(0, 2000));
            nw   = int'($urandom_range(0, 4));
            mode = int'($urandom_range(0, 2));
            poke = (nw > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(2, 40)) : -1;
            run_req(base, nw, mode, poke, $sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
